fir_tap_loader: RTL and testbench

//  Writer side of the FIR coefficient port. Accepts a coefficient frame on a config AXI-Stream,

---
 rtl/fir_cfg_pkg.sv | 18 +
 rtl/tap_shadow_ram.sv | 32 +++
 rtl/fir_tap_loader.sv | 184 ++++++++++++++++++
 tb/tb_fir_tap_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// Shared constants for the FIR coefficient loader: FSM encodings, error codes, tap address width.
package fir_cfg_pkg;

  localparam int FIR_TAP_ADDR_W = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_APPLY = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_LONG    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/tap_shadow_ram.sv
// Shadow coefficient buffer: one write port fed by the stream, one registered read port for apply.
module tap_shadow_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 51,
  parameter int AW    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Only the read register is reset so the tap data output is 0 out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_tap_loader.sv
// Collects a coefficient frame into the shadow buffer, validates its length and gaps,
// then writes it tap by tap into the FIR unit during granted windows.
//
//   state | meaning
//   IDLE  | waiting for the first word of a frame
//   RECV  | storing words 1..N-1 into the shadow
//   DRAIN | frame too long, discarding until tlast
//   APPLY | reading shadow and strobing taps on granted cycles
//   DONE  | one-cycle load_done pulse
//   ERR   | one-cycle load_err pulse
module fir_tap_loader
  import fir_cfg_pkg::*;
#(
  parameter int FIR_TAP_WIDTH = 32,
  parameter int FIR_TAP_NUM   = 51,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FIR_TAP_WIDTH-1:0]  s_axis_tap_tdata_i,
  input  logic                      s_axis_tap_tvalid_i,
  input  logic                      s_axis_tap_tlast_i,
  output logic                      s_axis_tap_tready_o,
  input  logic                      apply_en_i,
  output logic                      fir_tap_vld_o,
  output logic [FIR_TAP_ADDR_W-1:0] fir_tap_addr_o,
  output logic [FIR_TAP_WIDTH-1:0]  fir_tap_data_o,
  output logic                      load_busy_o,
  output logic                      load_done_o,
  output logic                      load_err_o,
  output logic [1:0]                err_code_o
);

  localparam int RAM_AW = (FIR_TAP_NUM > 1) ? $clog2(FIR_TAP_NUM) : 1;
  localparam int GAP_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0]          GAP_LOAD = GAP_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0]          GAP_TC   = GAP_W'(1);
  localparam logic [FIR_TAP_ADDR_W-1:0] LAST_IDX = FIR_TAP_ADDR_W'(FIR_TAP_NUM - 1);

  logic [2:0]                state_q, state_d;
  logic [FIR_TAP_ADDR_W-1:0] cnt_q, cnt_d;
  logic [FIR_TAP_ADDR_W-1:0] addr_q, addr_d;
  logic                      rd_last_q, rd_last_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [1:0]                err_q, err_d;
  logic                      tready_q, tready_d;
  logic                      vld_q;
  logic [FIR_TAP_ADDR_W-1:0] addr_out_q;

  logic                      accept;
  logic                      wr_en;
  logic                      rd_en;
  logic [FIR_TAP_ADDR_W-1:0] word_idx;
  logic                      last_word;
  logic                      short_frame;

  assign accept      = s_axis_tap_tvalid_i && tready_q;
  assign word_idx    = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign last_word   = (word_idx == LAST_IDX);
  // Inside IDLE/RECV the index never exceeds N-1, so "not last" means idx+1 < N.
  assign short_frame = s_axis_tap_tlast_i && !last_word;
  assign wr_en       = accept && ((state_q == ST_IDLE) || (state_q == ST_RECV));
  assign rd_en       = (state_q == ST_APPLY) && !rd_last_q && apply_en_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_last_d = rd_last_q;
    gap_d     = gap_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        gap_d     = GAP_LOAD;
        addr_d    = '0;
        rd_last_d = 1'b0;
        if (accept) begin
          err_d = ERR_NONE;
          cnt_d = FIR_TAP_ADDR_W'(1);
          if (short_frame) begin
            state_d = ST_ERR;
            err_d   = ERR_SHORT;
          end else if (last_word) begin
            state_d = s_axis_tap_tlast_i ? ST_APPLY : ST_DRAIN;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          gap_d = GAP_LOAD;
          cnt_d = cnt_q + 1'b1;
          if (short_frame) begin
            state_d = ST_ERR;
            err_d   = ERR_SHORT;
          end else if (last_word) begin
            state_d = s_axis_tap_tlast_i ? ST_APPLY : ST_DRAIN;
          end
        end else if (gap_q == GAP_TC) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          gap_d = GAP_LOAD;
          if (s_axis_tap_tlast_i) begin
            state_d = ST_ERR;
            err_d   = ERR_LONG;
          end
        end else if (gap_q == GAP_TC) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_APPLY: begin
        // Stay one cycle past the last read so the final strobe lands in APPLY.
        if (rd_last_q) begin
          state_d = ST_DONE;
        end else if (apply_en_i) begin
          if (addr_q == LAST_IDX) rd_last_d = 1'b1;
          else                    addr_d    = addr_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    tready_d = (state_d == ST_IDLE) || (state_d == ST_RECV) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rd_last_q  <= 1'b0;
      gap_q      <= GAP_LOAD;
      err_q      <= ERR_NONE;
      tready_q   <= 1'b0;
      vld_q      <= 1'b0;
      addr_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_last_q <= rd_last_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      tready_q  <= tready_d;
      vld_q     <= rd_en;
      if (rd_en) addr_out_q <= addr_q;
    end
  end

  tap_shadow_ram #(
    .WIDTH (FIR_TAP_WIDTH),
    .DEPTH (FIR_TAP_NUM),
    .AW    (RAM_AW)
  ) u_shadow (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (word_idx[RAM_AW-1:0]),
    .wr_data_i (s_axis_tap_tdata_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (addr_q[RAM_AW-1:0]),
    .rd_data_o (fir_tap_data_o)
  );

  assign s_axis_tap_tready_o = tready_q;
  assign fir_tap_vld_o       = vld_q;
  assign fir_tap_addr_o      = addr_out_q;
  assign load_busy_o         = (state_q == ST_RECV) || (state_q == ST_DRAIN) || (state_q == ST_APPLY);
  assign load_done_o         = (state_q == ST_DONE);
  assign load_err_o          = (state_q == ST_ERR);
  assign err_code_o          = err_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader: good/short/long/timeout frames, gated apply, mid-apply reset.
module tb_fir_tap_loader;

  localparam int NTAP = 51;
  localparam int TMO  = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] s_axis_tap_tdata_i;
  logic        s_axis_tap_tvalid_i;
  logic        s_axis_tap_tlast_i;
  logic        s_axis_tap_tready_o;
  logic        apply_en_i;
  logic        fir_tap_vld_o;
  logic [9:0]  fir_tap_addr_o;
  logic [31:0] fir_tap_data_o;
  logic        load_busy_o;
  logic        load_done_o;
  logic        load_err_o;
  logic [1:0]  err_code_o;

  int vecs = 0;
  int errs = 0;

  fir_tap_loader #(
    .FIR_TAP_WIDTH (32),
    .FIR_TAP_NUM   (NTAP),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .s_axis_tap_tdata_i  (s_axis_tap_tdata_i),
    .s_axis_tap_tvalid_i (s_axis_tap_tvalid_i),
    .s_axis_tap_tlast_i  (s_axis_tap_tlast_i),
    .s_axis_tap_tready_o (s_axis_tap_tready_o),
    .apply_en_i          (apply_en_i),
    .fir_tap_vld_o       (fir_tap_vld_o),
    .fir_tap_addr_o      (fir_tap_addr_o),
    .fir_tap_data_o      (fir_tap_data_o),
    .load_busy_o         (load_busy_o),
    .load_done_o         (load_done_o),
    .load_err_o          (load_err_o),
    .err_code_o          (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vecs);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input int n, input int last_idx, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      s_axis_tap_tvalid_i = 1'b1;
      s_axis_tap_tdata_i  = base + 32'(k);
      s_axis_tap_tlast_i  = (k == last_idx);
      check("word_tready", {31'd0, s_axis_tap_tready_o}, 32'd1);
      step();
    end
    s_axis_tap_tvalid_i = 1'b0;
    s_axis_tap_tlast_i  = 1'b0;
  endtask

  task automatic run_apply(input bit toggle, input logic [31:0] base);
    int nstrobe;
    int it;
    bit en;
    nstrobe = 0;
    it      = 0;
    check("apply_busy", {31'd0, load_busy_o}, 32'd1);
    while (nstrobe < NTAP && it < 400) begin
      en = toggle ? ((it % 4 == 0) || (it % 4 == 3)) : 1'b1;
      apply_en_i = en;
      step();
      check("strobe_vld", {31'd0, fir_tap_vld_o}, {31'd0, en});
      if (fir_tap_vld_o) begin
        check("strobe_addr", {22'd0, fir_tap_addr_o}, 32'(nstrobe));
        check("strobe_data", fir_tap_data_o, base + 32'(nstrobe));
        nstrobe++;
      end
      it++;
    end
    check("strobe_count", 32'(nstrobe), 32'(NTAP));
    apply_en_i = 1'b1;
    step();
    check("done_pulse", {31'd0, load_done_o}, 32'd1);
    check("done_no_vld", {31'd0, fir_tap_vld_o}, 32'd0);
    check("done_busy", {31'd0, load_busy_o}, 32'd0);
    step();
    check("done_end", {31'd0, load_done_o}, 32'd0);
    check("idle_tready", {31'd0, s_axis_tap_tready_o}, 32'd1);
    check("idle_err_code", {30'd0, err_code_o}, 32'd0);
    apply_en_i = 1'b0;
  endtask

  initial begin
    rst_i               = 1'b1;
    s_axis_tap_tdata_i  = '0;
    s_axis_tap_tvalid_i = 1'b0;
    s_axis_tap_tlast_i  = 1'b0;
    apply_en_i          = 1'b0;
    step();
    step();
    check("rst_tready", {31'd0, s_axis_tap_tready_o}, 32'd0);
    check("rst_vld", {31'd0, fir_tap_vld_o}, 32'd0);
    check("rst_addr", {22'd0, fir_tap_addr_o}, 32'd0);
    check("rst_data", fir_tap_data_o, 32'd0);
    check("rst_busy", {31'd0, load_busy_o}, 32'd0);
    check("rst_done", {31'd0, load_done_o}, 32'd0);
    check("rst_err", {31'd0, load_err_o}, 32'd0);
    check("rst_code", {30'd0, err_code_o}, 32'd0);
    rst_i = 1'b0;
    check("rst_tready_hold", {31'd0, s_axis_tap_tready_o}, 32'd0);
    step();
    check("tready_rise", {31'd0, s_axis_tap_tready_o}, 32'd1);

    // 1: full good frame, apply always granted
    send_frame(NTAP, NTAP - 1, 32'h100);
    check("t1_apply_tready", {31'd0, s_axis_tap_tready_o}, 32'd0);
    run_apply(1'b0, 32'h100);

    // 2: short frame, then a clean reload with new data
    send_frame(21, 20, 32'h100);
    check("t2_err_pulse", {31'd0, load_err_o}, 32'd1);
    check("t2_err_code", {30'd0, err_code_o}, 32'd1);
    check("t2_tready", {31'd0, s_axis_tap_tready_o}, 32'd0);
    check("t2_vld", {31'd0, fir_tap_vld_o}, 32'd0);
    step();
    check("t2_err_end", {31'd0, load_err_o}, 32'd0);
    check("t2_code_hold", {30'd0, err_code_o}, 32'd1);
    check("t2_vld_after", {31'd0, fir_tap_vld_o}, 32'd0);
    send_frame(NTAP, NTAP - 1, 32'h200);
    run_apply(1'b0, 32'h200);

    // 3: long frame drains to tlast
    send_frame(55, 54, 32'h300);
    check("t3_err_pulse", {31'd0, load_err_o}, 32'd1);
    check("t3_err_code", {30'd0, err_code_o}, 32'd2);
    check("t3_vld", {31'd0, fir_tap_vld_o}, 32'd0);
    step();
    check("t3_vld_after", {31'd0, fir_tap_vld_o}, 32'd0);
    check("t3_tready", {31'd0, s_axis_tap_tready_o}, 32'd1);

    // 4: gap timeout after 10 words
    send_frame(10, -1, 32'h400);
    for (int i = 0; i < TMO - 1; i++) step();
    check("t4_pre_tready", {31'd0, s_axis_tap_tready_o}, 32'd1);
    check("t4_pre_err", {31'd0, load_err_o}, 32'd0);
    check("t4_pre_busy", {31'd0, load_busy_o}, 32'd1);
    step();
    check("t4_err_pulse", {31'd0, load_err_o}, 32'd1);
    check("t4_err_code", {30'd0, err_code_o}, 32'd3);
    step();
    send_frame(NTAP, NTAP - 1, 32'h500);
    run_apply(1'b0, 32'h500);

    // 5: apply window toggling 1,0,0,1
    send_frame(NTAP, NTAP - 1, 32'h600);
    run_apply(1'b1, 32'h600);

    // 6: reset in the middle of apply
    send_frame(NTAP, NTAP - 1, 32'h700);
    apply_en_i = 1'b1;
    for (int i = 0; i < 25; i++) step();
    check("t6_pre_vld", {31'd0, fir_tap_vld_o}, 32'd1);
    check("t6_pre_addr", {22'd0, fir_tap_addr_o}, 32'd24);
    rst_i = 1'b1;
    step();
    check("t6_vld", {31'd0, fir_tap_vld_o}, 32'd0);
    check("t6_busy", {31'd0, load_busy_o}, 32'd0);
    check("t6_tready", {31'd0, s_axis_tap_tready_o}, 32'd0);
    rst_i      = 1'b0;
    apply_en_i = 1'b0;
    step();
    check("t6_tready_rise", {31'd0, s_axis_tap_tready_o}, 32'd1);
    check("t6_vld_idle", {31'd0, fir_tap_vld_o}, 32'd0);
    send_frame(NTAP, NTAP - 1, 32'h800);
    run_apply(1'b0, 32'h800);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
